// File: rtl/booth_mul_radix4_seq_pkg.sv
// Shared types for the radix-4 Booth sequencer: FSM states, Booth select codes and window decode.
// Pure declarations; no latency or flow control of its own.
package booth_mul_radix4_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_P1   = 3'd1,
    SEL_P2   = 3'd2,
    SEL_N1   = 3'd3,
    SEL_N2   = 3'd4
  } sel_t;

  // Window is {q[1], q[0], q[-1]}.
  function automatic sel_t booth_sel(input logic [2:0] win);
    case (win)
      3'b001, 3'b010: return SEL_P1;
      3'b011:         return SEL_P2;
      3'b100:         return SEL_N2;
      3'b101, 3'b110: return SEL_N1;
      default:        return SEL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_step_r4.sv
// One radix-4 Booth step: add 0/+-M/+-2M to acc, then shift {acc, q, q[-1]} right by 2 arithmetically.
// Purely combinational (zero latency); no handshake, the sequencer owns all state.
module booth_step_r4
  import booth_mul_radix4_seq_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH+2:0] acc_in,
  input  logic [WIDTH+1:0] q_in,
  input  logic [2:0]       window,
  input  logic [WIDTH+1:0] m_ext,
  output logic [WIDTH+2:0] acc_out,
  output logic [WIDTH+1:0] q_out,
  output logic             q_m1_out
);

  localparam int AW = WIDTH + 3;
  localparam int CW = 2*WIDTH + 6;

  sel_t          sel;
  logic [AW-1:0] m_acc;
  logic [AW-1:0] addend;
  logic [AW-1:0] sum;
  logic [CW-1:0] chain;
  logic [CW-1:0] shifted;

  always_comb begin
    sel    = booth_sel(window);
    m_acc  = {m_ext[WIDTH+1], m_ext};
    addend = '0;
    case (sel)
      SEL_P1:  addend = m_acc;
      SEL_P2:  addend = m_acc << 1;
      SEL_N1:  addend = -m_acc;
      SEL_N2:  addend = -(m_acc << 1);
      default: addend = '0;
    endcase
    sum     = acc_in + addend;
    // The incoming q[-1] rides along so the shift drops exactly the two consumed multiplier bits.
    chain   = {sum, q_in, window[0]};
    shifted = $signed(chain) >>> 2;
  end

  assign acc_out  = shifted[CW-1:WIDTH+3];
  assign q_out    = shifted[WIDTH+2:1];
  assign q_m1_out = shifted[0];

endmodule

// File: rtl/booth_mul_radix4_seq.sv
// Iterative radix-4 Booth multiplier, signed/unsigned; op_done rises WIDTH/2+1 cycles after op_start is taken.
// No backpressure: op_start is only honoured in IDLE, and the result is held until op_clear.
module booth_mul_radix4_seq
  import booth_mul_radix4_seq_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] result,
  output logic               op_done,
  output logic               busy
);

  localparam int N_STEPS = WIDTH/2 + 1;
  localparam int CNT_W   = $clog2(WIDTH/2 + 1);

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("booth_mul_radix4_seq: WIDTH must be even and >= 4");
  end

  state_t           state;
  logic [WIDTH+2:0] acc;
  logic [WIDTH+1:0] q;
  logic             q_m1;
  logic [WIDTH+1:0] m_ext;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH+2:0] acc_nxt;
  logic [WIDTH+1:0] q_nxt;
  logic             q_m1_nxt;

  booth_step_r4 #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_in   (acc),
    .q_in     (q),
    .window   ({q[1:0], q_m1}),
    .m_ext    (m_ext),
    .acc_out  (acc_nxt),
    .q_out    (q_nxt),
    .q_m1_out (q_m1_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      acc     <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      m_ext   <= '0;
      cnt     <= '0;
      result  <= '0;
      op_done <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!op_clear && op_start) begin
            // Two extension bits so the extra step consumes them and unsigned all-ones stays positive.
            m_ext <= signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                 : {2'b00, multiplicand};
            q     <= signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                                 : {2'b00, multiplier};
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (op_clear) begin
            state   <= IDLE;
            busy    <= 1'b0;
            result  <= '0;
            op_done <= 1'b0;
          end else begin
            acc  <= acc_nxt;
            q    <= q_nxt;
            q_m1 <= q_m1_nxt;
            cnt  <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(N_STEPS - 1)) begin
              state   <= DONE;
              busy    <= 1'b0;
              op_done <= 1'b1;
              result  <= {acc_nxt[WIDTH-3:0], q_nxt};
            end
          end
        end
        DONE: begin
          if (op_clear) begin
            state   <= IDLE;
            result  <= '0;
            op_done <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_radix4_seq.sv
// Scoreboard bench for the radix-4 Booth multiplier at WIDTH=64 and WIDTH=8.
module tb_booth_mul_radix4_seq;

  localparam int W  = 64;
  localparam int W8 = 8;
  localparam int N  = W/2 + 1;
  localparam int N8 = W8/2 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             op_start, op_clear, signed_mode;
  logic [W-1:0]     mcand, mplier;
  logic [2*W-1:0]   result;
  logic             op_done, busy;

  logic             op_start8, op_clear8, signed_mode8;
  logic [W8-1:0]    mcand8, mplier8;
  logic [2*W8-1:0]  result8;
  logic             op_done8, busy8;

  booth_mul_radix4_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .signed_mode  (signed_mode),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .result       (result),
    .op_done      (op_done),
    .busy         (busy)
  );

  booth_mul_radix4_seq #(.WIDTH(W8)) dut8 (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_start     (op_start8),
    .op_clear     (op_clear8),
    .signed_mode  (signed_mode8),
    .multiplicand (mcand8),
    .multiplier   (mplier8),
    .result       (result8),
    .op_done      (op_done8),
    .busy         (busy8)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [2*W-1:0]  prod; int acc_cyc; } exp64_t;
  typedef struct { logic [2*W8-1:0] prod; int acc_cyc; } exp8_t;
  exp64_t sb64[$];
  exp8_t  sb8[$];

  // Reference: extend each operand to the full product width, multiply, keep the low bits.
  function automatic logic [2*W-1:0] ref64(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [2*W-1:0] ae, be;
    ae = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    be = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ae * be;
  endfunction

  function automatic logic [2*W8-1:0] ref8(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic s);
    logic [2*W8-1:0] ae, be;
    ae = s ? {{W8{a[W8-1]}}, a} : {{W8{1'b0}}, a};
    be = s ? {{W8{b[W8-1]}}, b} : {{W8{1'b0}}, b};
    return ae * be;
  endfunction

  function automatic logic [W-1:0] rnd64();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop on each rising op_done, check product, latency and busy length.
  logic prev_done64 = 1'b0;
  int   run64 = 0;
  always @(negedge clk) begin
    exp64_t e;
    if (op_done && !prev_done64) begin
      if (sb64.size() == 0) begin
        chk("unexpected_done64", 128'(op_done), 128'(0));
      end else begin
        e = sb64.pop_front();
        chk("result64", result, e.prod);
        chk_i("latency64", cyc - e.acc_cyc, N);
        chk_i("busy_len64", run64, N);
      end
      run64 = 0;
    end else if (busy) begin
      run64++;
    end else begin
      run64 = 0;
    end
    prev_done64 = op_done;
  end

  logic prev_done8 = 1'b0;
  int   run8 = 0;
  always @(negedge clk) begin
    exp8_t e;
    if (op_done8 && !prev_done8) begin
      if (sb8.size() == 0) begin
        chk("unexpected_done8", 128'(op_done8), 128'(0));
      end else begin
        e = sb8.pop_front();
        chk("result8", 128'(result8), 128'(e.prod));
        chk_i("latency8", cyc - e.acc_cyc, N8);
        chk_i("busy_len8", run8, N8);
      end
      run8 = 0;
    end else if (busy8) begin
      run8++;
    end else begin
      run8 = 0;
    end
    prev_done8 = op_done8;
  end

  task automatic start_raw64(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(posedge clk); #1;
    mcand = a; mplier = b; signed_mode = s; op_start = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
    mcand = {$urandom, $urandom}; mplier = {$urandom, $urandom}; signed_mode = 1'($urandom);
  endtask

  task automatic op64(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp64_t e;
    int     t;
    start_raw64(a, b, s);
    e.prod = ref64(a, b, s);
    e.acc_cyc = cyc;
    sb64.push_back(e);
    t = 0;
    while (!op_done && t < N + 10) begin
      @(negedge clk);
      t++;
    end
    if (!op_done) chk("timeout64", 128'(op_done), 128'(1));
    // op_start in DONE must not disturb the held product.
    op_start = 1'b1;
    repeat (3) @(negedge clk);
    op_start = 1'b0;
    chk("hold64", result, e.prod);
    chk("hold_done64", 128'(op_done), 128'(1));
    @(posedge clk); #1 op_clear = 1'b1;
    @(posedge clk); #1 op_clear = 1'b0;
    chk("clr_result64", result, 128'(0));
    chk("clr_done64", 128'(op_done), 128'(0));
  endtask

  task automatic op8(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic s);
    exp8_t e;
    int    t;
    @(posedge clk); #1;
    mcand8 = a; mplier8 = b; signed_mode8 = s; op_start8 = 1'b1;
    @(posedge clk); #1;
    op_start8 = 1'b0;
    mcand8 = W8'($urandom); mplier8 = W8'($urandom); signed_mode8 = 1'($urandom);
    e.prod = ref8(a, b, s);
    e.acc_cyc = cyc;
    sb8.push_back(e);
    t = 0;
    while (!op_done8 && t < N8 + 10) begin
      @(negedge clk);
      t++;
    end
    if (!op_done8) chk("timeout8", 128'(op_done8), 128'(1));
    @(posedge clk); #1 op_clear8 = 1'b1;
    @(posedge clk); #1 op_clear8 = 1'b0;
    chk("clr_result8", 128'(result8), 128'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    op_start = 1'b0; op_clear = 1'b0; signed_mode = 1'b0; mcand = '0; mplier = '0;
    op_start8 = 1'b0; op_clear8 = 1'b0; signed_mode8 = 1'b0; mcand8 = '0; mplier8 = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_result64", result, 128'(0));
    chk("rst_done64", 128'(op_done), 128'(0));
    chk("rst_busy64", 128'(busy), 128'(0));
    chk("rst_result8", 128'(result8), 128'(0));
    chk("rst_done8", 128'(op_done8), 128'(0));
    chk("rst_busy8", 128'(busy8), 128'(0));
    @(negedge clk) reset_n = 1'b1;

    op64(64'd3, 64'd5, 1'b0);
    op64('1, 64'd1, 1'b1);
    op64('1, '1, 1'b0);
    op64({1'b1, 63'b0}, {1'b1, 63'b0}, 1'b1);

    // Abort mid-EXEC, with a stray op_start that must be ignored.
    start_raw64(rnd64(), rnd64(), 1'b1);
    repeat (5) @(posedge clk); #1;
    op_start = 1'b1; mcand = 64'd3; mplier = 64'd3;
    repeat (3) @(posedge clk); #1;
    chk("busy_before_clr", 128'(busy), 128'(1));
    op_clear = 1'b1;
    @(posedge clk); #1;
    op_clear = 1'b0; op_start = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_done", 128'(op_done), 128'(0));
    chk("abort_result", result, 128'(0));
    repeat (N + 5) @(negedge clk);
    chk("abort_no_done", 128'(op_done), 128'(0));

    // op_clear beats op_start in IDLE.
    @(posedge clk); #1 op_start = 1'b1; op_clear = 1'b1;
    @(posedge clk); #1 op_start = 1'b0; op_clear = 1'b0;
    chk("clear_wins_busy", 128'(busy), 128'(0));

    op64(64'd7, 64'd6, 1'b0);

    // Asynchronous reset in the middle of EXEC.
    start_raw64(rnd64(), rnd64(), 1'b0);
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_done", 128'(op_done), 128'(0));
    chk("midrst_result", result, 128'(0));
    @(negedge clk) reset_n = 1'b1;
    repeat (N + 5) @(negedge clk);
    chk("midrst_no_done", 128'(op_done), 128'(0));

    for (int i = 0; i < 30; i++) begin
      op64(rnd64(), rnd64(), 1'($urandom));
    end

    op8(8'h80, 8'h7F, 1'b1);
    op8(8'hFF, 8'hFF, 1'b0);
    op8(8'h80, 8'h80, 1'b1);
    op8(8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 60; i++) begin
      op8(W8'($urandom), W8'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk_i("leftover64", sb64.size(), 0);
    chk_i("leftover8", sb8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_mul_radix4_seq.md
Name: booth_mul_radix4_seq

Overview:
- Parametrised, iterative radix-4 Booth multiplier: WIDTH x WIDTH -> 2*WIDTH product, signed or unsigned per operation.
- Retires one Booth recoding step (3-bit window, add/sub of 0, ±M, ±2M, then arithmetic shift right by 2) per clock.
- Sits on the datapath as a multi-cycle functional unit with a start/done/clear handshake.
- Successor of the single-step combinational Booth cell: adds width generality, a signed/unsigned mode, a sequencer, and abort.

Parameters:
- WIDTH, 64, operand width in bits; must be even and >= 4 (elaboration error otherwise).
- CNT_W, $clog2(WIDTH/2+1), step counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- op_start  input  1  start request; sampled only in IDLE.
- op_clear  input  1  abort/acknowledge; returns the block to IDLE from any state.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with op_start.
- multiplicand  input  WIDTH  operand M; captured with op_start.
- multiplier  input  WIDTH  operand Q; captured with op_start.
- result  output  2*WIDTH  product, valid while op_done = 1.
- op_done  output  1  product valid.
- busy  output  1  high in EXEC.

Behaviour:
- Reset (reset_n low, asynchronous): state = IDLE, result = 0, op_done = 0, busy = 0, counter = 0, internal registers = 0.
- Step count: N = WIDTH/2 + 1 for both modes, so latency is uniform.
- Operand capture: operands are extended to WIDTH+2 bits, sign-extended if signed_mode = 1, zero-extended otherwise.
- Accumulator width: WIDTH+3 bits, so ±2M never overflows. Recoding window starts with an implicit q[-1] = 0.
- FSM IDLE:
  - op_clear = 1 -> stay in IDLE.
  - Otherwise, if op_start = 1: capture operands and mode, clear the accumulator, counter = 0, go to EXEC.
  - op_clear wins over a simultaneous op_start.
- FSM EXEC, each cycle:
  - Apply one Booth step with this recoding of bits {q[1], q[0], q[-1]}:
    - 000 and 111 -> +0
    - 001 and 010 -> +M
    - 011 -> +2M
    - 100 -> -2M
    - 101 and 110 -> -M
  - Then shift the {acc, Q, q[-1]} chain right arithmetically by 2 and increment the counter.
  - The step taken with counter == N-1 transitions to DONE.
  - op_start is ignored.
  - op_clear = 1 -> go to IDLE, result = 0, op_done stays 0, and no step is applied that cycle.
- FSM DONE:
  - result = low 2*WIDTH bits of the final {acc, Q} product, registered; op_done = 1.
  - Both hold until op_clear = 1, which returns the block to IDLE and clears result and op_done.
  - op_start is ignored while in DONE.
- Timing: op_start accepted at edge k -> op_done = 1 after edge k+N (WIDTH = 64: 33 cycles).
- busy = 1 exactly in the N EXEC cycles.
- Reset asserted mid-operation aborts immediately to the reset values; no partial result is visible.
- Unsigned mode: the extra step consumes the zero-extension bits, so all-ones operands produce the correct unsigned product.

Decomposition:
- Shared package / include: state encodings (IDLE = 2'b00, EXEC = 2'b01, DONE = 2'b10) and Booth select codes (SEL_ZERO, SEL_P1, SEL_P2, SEL_N1, SEL_N2).
- Sub-module booth_step_r4:
  - Purely combinational, parametrised by WIDTH.
  - Inputs: accumulator, Q chain, 3-bit window, extended M.
  - Output: next {acc, Q, q[-1]} after add/sub and the 2-bit arithmetic shift.
  - Instantiated once; the sequencer owns the registers and counter.

Test Plan:
- WIDTH = 64, unsigned, 3 x 5, op_start pulse -> busy high 33 cycles, op_done after edge 33, result = 128'd15; result holds until op_clear, then result = 0 and op_done = 0.
- WIDTH = 64, signed, 64'hFFFF_FFFF_FFFF_FFFF x 64'd1 -> result = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF.
- WIDTH = 64, unsigned, 64'hFFFF_FFFF_FFFF_FFFF squared -> result = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- WIDTH = 64, signed, 64'h8000_0000_0000_0000 squared -> result = 128'h4000_0000_0000_0000_0000_0000_0000_0000.
- Abort and ignore:
  - op_clear at the 10th EXEC cycle -> IDLE next edge, op_done never asserts, result = 0.
  - op_start during EXEC is ignored.
  - A fresh 7 x 6 unsigned operation then yields 42.
  - reset_n pulsed low mid-EXEC -> all outputs 0 immediately.
- WIDTH = 8 instance, signed, 8'h80 x 8'h7F -> result = 16'hC080 after 5 cycles; unsigned 8'hFF x 8'hFF -> 16'hFE01.
